// File: rtl/bt656_ycbcr_unpack.sv
// BT.656 byte-stream parser: tracks TRS codes and emits 4:4:4 pixels with
// column/line coordinates, field flag and line/frame start strobes.
module bt656_ycbcr_unpack #(
    parameter int unsigned MAX_PIX = 720,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    din,
    input  logic          din_valid,
    output logic [7:0]    y,
    output logic [7:0]    cb,
    output logic [7:0]    cr,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] line_y,
    output logic          field,
    output logic          sol,
    output logic          sof,
    output logic          trs_err
);

    localparam int unsigned CW = $clog2(MAX_PIX + 1);

    typedef enum logic [2:0] {
        BLANK, TRS1, TRS2, TRS3, A_CB, A_Y0, A_CR, A_Y1
    } state_t;

    state_t        state;
    logic [7:0]    cb_hold;
    logic [7:0]    y0_hold;
    logic [7:0]    cr_hold;
    logic [CW-1:0] count;
    logic [YW-1:0] line_cnt;
    logic          prev_v;
    logic          sof_arm;

    logic          xy_f, xy_v, xy_h, xy_ok_c;
    logic          count_full_c;
    logic          emit_c;
    logic [7:0]    emit_y_c;
    logic [7:0]    emit_cr_c;

    // XY code fields and Hamming protection check
    assign xy_f    = din[6];
    assign xy_v    = din[5];
    assign xy_h    = din[4];
    assign xy_ok_c = din[7]
                   && (din[3] == (xy_v ^ xy_h))
                   && (din[2] == (xy_f ^ xy_h))
                   && (din[1] == (xy_f ^ xy_v))
                   && (din[0] == (xy_f ^ xy_v ^ xy_h));

    assign count_full_c = (count == CW'(MAX_PIX));

    // Pixel emission decision: Cr byte pairs with held Y0, Y1 byte with held Cr
    always_comb begin
        emit_c    = 1'b0;
        emit_y_c  = din;
        emit_cr_c = din;
        if (din_valid && (din != 8'hFF) && !count_full_c) begin
            if (state == A_CR) begin
                emit_c    = 1'b1;
                emit_y_c  = y0_hold;
                emit_cr_c = din;
            end else if (state == A_Y1) begin
                emit_c    = 1'b1;
                emit_y_c  = din;
                emit_cr_c = cr_hold;
            end
        end
    end

    // Parser state, sample holding, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BLANK;
            cb_hold   <= 8'd0;
            y0_hold   <= 8'd0;
            cr_hold   <= 8'd0;
            count     <= '0;
            line_cnt  <= '0;
            prev_v    <= 1'b1;
            sof_arm   <= 1'b0;
            y         <= 8'd16;
            cb        <= 8'd128;
            cr        <= 8'd128;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            line_y    <= '0;
            field     <= 1'b0;
            sol       <= 1'b0;
            sof       <= 1'b0;
            trs_err   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            sol       <= 1'b0;
            sof       <= 1'b0;
            trs_err   <= 1'b0;
            if (din_valid) begin
                if (din == 8'hFF) begin
                    state <= TRS1;
                end else begin
                    case (state)
                        BLANK: state <= BLANK;
                        TRS1: begin
                            if (din == 8'h00) begin
                                state <= TRS2;
                            end else begin
                                state   <= BLANK;
                                trs_err <= 1'b1;
                            end
                        end
                        TRS2: begin
                            if (din == 8'h00) begin
                                state <= TRS3;
                            end else begin
                                state   <= BLANK;
                                trs_err <= 1'b1;
                            end
                        end
                        TRS3: begin
                            if (!xy_ok_c) begin
                                state   <= BLANK;
                                trs_err <= 1'b1;
                            end else begin
                                field  <= xy_f;
                                prev_v <= xy_v;
                                if (!xy_h && !xy_v) begin
                                    state    <= A_CB;
                                    count    <= '0;
                                    sof_arm  <= prev_v;
                                    line_cnt <= prev_v ? '0 : line_cnt + YW'(1);
                                end else begin
                                    state <= BLANK;
                                end
                            end
                        end
                        A_CB: begin
                            cb_hold <= din;
                            state   <= A_Y0;
                        end
                        A_Y0: begin
                            y0_hold <= din;
                            state   <= A_CR;
                        end
                        A_CR: begin
                            cr_hold <= din;
                            state   <= A_Y1;
                        end
                        A_Y1: state <= A_CB;
                        default: state <= BLANK;
                    endcase
                end
                if (emit_c) begin
                    pix_valid <= 1'b1;
                    y         <= emit_y_c;
                    cb        <= cb_hold;
                    cr        <= emit_cr_c;
                    pix_x     <= XW'(count);
                    line_y    <= line_cnt;
                    sol       <= (count == '0);
                    sof       <= (count == '0) && sof_arm;
                    if (count == '0) begin
                        sof_arm <= 1'b0;
                    end
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bt656_ycbcr_unpack.sv
// Testbench for bt656_ycbcr_unpack: vector table, directed streams and a
// randomized stream checked against a stream-parsing reference model.
module tb_bt656_ycbcr_unpack;

    localparam int unsigned MAX_PIX = 720;
    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [7:0]    din;
    logic          din_valid;
    logic [7:0]    y, cb, cr;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] line_y;
    logic          field, sol, sof, trs_err;

    bt656_ycbcr_unpack #(.MAX_PIX(MAX_PIX), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .y(y), .cb(cb), .cr(cr), .pix_valid(pix_valid), .pix_x(pix_x),
        .line_y(line_y), .field(field), .sol(sol), .sof(sof), .trs_err(trs_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          pv, sol, sof, err, fld;
        logic [7:0]    y, cb, cr;
        logic [XW-1:0] x;
        logic [YW-1:0] ln;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic       dv;
        exp_t       e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] stim[$];
    exp_t       expq[$];
    exp_t       m_hold;
    logic       m_prev_v;
    int         m_line;

    int npix, nsof, nerr, last_x;
    int sol_lines[$];

    function automatic exp_t reset_exp();
        exp_t e;
        e.pv = 0; e.sol = 0; e.sof = 0; e.err = 0; e.fld = 0;
        e.y = 8'd16; e.cb = 8'd128; e.cr = 8'd128; e.x = '0; e.ln = '0;
        return e;
    endfunction

    function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    task automatic check(input string name, input exp_t e);
        n_cmp++;
        if (pix_valid !== e.pv || y !== e.y || cb !== e.cb || cr !== e.cr ||
            pix_x !== e.x || line_y !== e.ln || field !== e.fld ||
            sol !== e.sol || sof !== e.sof || trs_err !== e.err) begin
            n_bad++;
            $display("FAIL %s @%0t: got pv=%0b y=%h cb=%h cr=%h x=%0d ln=%0d f=%0b sol=%0b sof=%0b err=%0b; want pv=%0b y=%h cb=%h cr=%h x=%0d ln=%0d f=%0b sol=%0b sof=%0b err=%0b",
                     name, $time, pix_valid, y, cb, cr, pix_x, line_y, field, sol, sof, trs_err,
                     e.pv, e.y, e.cb, e.cr, e.x, e.ln, e.fld, e.sol, e.sof, e.err);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_hold   = reset_exp();
        m_prev_v = 1'b1;
        m_line   = 0;
    endtask

    // Reference: locate TRS codes in the byte list, then derive pixels from byte
    // positions inside each active segment (Cb Y0 Cr Y1 quads).
    task automatic model_build();
        int n = stim.size();
        int i = 0;
        int s, e, idx;
        logic first;
        logic [7:0] xy;
        bit ev_pix[], ev_err[], ev_fset[], ev_fval[], ev_sof[];
        logic [7:0] ey[], ecb[], ecr[];
        int ex[], eln[];
        exp_t cur, r;
        ev_pix = new[n]; ev_err = new[n]; ev_fset = new[n]; ev_fval = new[n]; ev_sof = new[n];
        ey = new[n]; ecb = new[n]; ecr = new[n]; ex = new[n]; eln = new[n];
        expq.delete();
        while (i < n) begin
            if (stim[i] != 8'hFF) begin i++; continue; end
            if (i + 1 >= n) break;
            if (stim[i+1] == 8'hFF) begin i += 1; continue; end
            if (stim[i+1] != 8'h00) begin ev_err[i+1] = 1; i += 2; continue; end
            if (i + 2 >= n) break;
            if (stim[i+2] == 8'hFF) begin i += 2; continue; end
            if (stim[i+2] != 8'h00) begin ev_err[i+2] = 1; i += 3; continue; end
            if (i + 3 >= n) break;
            xy = stim[i+3];
            if (xy == 8'hFF) begin i += 3; continue; end
            if (xy != xy_code(xy[6], xy[5], xy[4])) begin ev_err[i+3] = 1; i += 4; continue; end
            ev_fset[i+3] = 1;
            ev_fval[i+3] = xy[6];
            if (xy[4] || xy[5]) begin m_prev_v = xy[5]; i += 4; continue; end
            first    = m_prev_v;
            m_prev_v = 1'b0;
            m_line   = first ? 0 : (m_line + 1) % (1 << YW);
            s = i + 4;
            e = s;
            while (e < n && stim[e] != 8'hFF) e++;
            for (int b = 0; b < e - s; b++) begin
                if (b % 4 >= 2) begin
                    idx = (b / 4) * 2 + ((b % 4 == 3) ? 1 : 0);
                    if (idx < MAX_PIX) begin
                        ev_pix[s+b] = 1;
                        ecb[s+b]    = stim[s + b - (b % 4)];
                        ey[s+b]     = (b % 4 == 2) ? stim[s+b-1] : stim[s+b];
                        ecr[s+b]    = (b % 4 == 2) ? stim[s+b] : stim[s+b-1];
                        ex[s+b]     = idx;
                        eln[s+b]    = m_line;
                        ev_sof[s+b] = first && (idx == 0);
                    end
                end
            end
            i = e;
        end
        cur = m_hold;
        for (int k = 0; k < n; k++) begin
            if (ev_fset[k]) cur.fld = ev_fval[k];
            if (ev_pix[k]) begin
                cur.y = ey[k]; cur.cb = ecb[k]; cur.cr = ecr[k];
                cur.x = XW'(ex[k]); cur.ln = YW'(eln[k]);
            end
            r     = cur;
            r.pv  = ev_pix[k];
            r.sol = ev_pix[k] && (ex[k] == 0);
            r.sof = ev_pix[k] && ev_sof[k];
            r.err = ev_err[k];
            expq.push_back(r);
        end
        m_hold = cur;
    endtask

    // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idle cycles
    task automatic run_stream(input string name, input int gap_mode);
        exp_t hold;
        exp_t idle;
        hold = m_hold;
        model_build();
        npix = 0; nsof = 0; nerr = 0; last_x = -1;
        sol_lines.delete();
        for (int i = 0; i < stim.size(); i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                @(negedge clock);
                din       = 8'($urandom_range(0, 255));
                din_valid = 1'b0;
                @(posedge clock);
                #1;
                idle = hold;
                check({name, "_idle"}, idle);
            end
            @(negedge clock);
            din       = stim[i];
            din_valid = 1'b1;
            @(posedge clock);
            #1;
            check(name, expq[i]);
            if (pix_valid === 1'b1) begin npix++; last_x = int'(pix_x); end
            if (sol === 1'b1) sol_lines.push_back(int'(line_y));
            if (sof === 1'b1) nsof++;
            if (trs_err === 1'b1) nerr++;
            hold = expq[i];
            hold.pv = 0; hold.sol = 0; hold.sof = 0; hold.err = 0;
        end
        @(negedge clock);
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("reset", reset_exp());
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        stim.push_back(b0); stim.push_back(b1); stim.push_back(b2); stim.push_back(b3);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic dv, input logic pv,
                                input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr,
                                input int ex, input logic esol, input logic esof, input logic eerr);
        vec_t v;
        v.din = d; v.dv = dv;
        v.e = reset_exp();
        v.e.pv = pv; v.e.y = ey; v.e.cb = ecb; v.e.cr = ecr; v.e.x = XW'(ex);
        v.e.sol = esol; v.e.sof = esof; v.e.err = eerr;
        return v;
    endfunction

    task automatic gen_random(input int nlines);
        logic f, v;
        logic [7:0] xy;
        int kind;
        stim.delete();
        for (int l = 0; l < nlines; l++) begin
            kind = $urandom_range(0, 9);
            f = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 4)) stim.push_back(8'($urandom_range(0, 254)));
            stim.push_back(8'hFF);
            if (kind == 0) begin
                stim.push_back(8'($urandom_range(0, 254)));
                continue;
            end
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            xy = (kind == 1) ? 8'($urandom_range(0, 254)) : xy_code(f, v, 1'b0);
            stim.push_back(xy);
            repeat ($urandom_range(0, 60)) stim.push_back(8'($urandom_range(0, 254)));
            if ($urandom_range(0, 1) == 1) push_bytes(8'hFF, 8'h00, 8'h00, xy_code(f, v, 1'b1));
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset_n   = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;

        // Vector table: SAV, one quad with idle cycles, EAV, broken preamble, bad XY
        do_reset();
        tbl.push_back(mk(8'hFF, 1, 0, 8'h10 + 8'h00, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl[0].e.y = 8'd16;
        tbl.push_back(mk(8'h00, 1, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h80, 1, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h80, 1, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h10, 0, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h10, 1, 0, 8'd16, 8'd128, 8'd128, 0, 0, 0, 0));
        tbl.push_back(mk(8'h90, 1, 1, 8'h10, 8'h80, 8'h90, 0, 1, 1, 0));
        tbl.push_back(mk(8'h33, 0, 0, 8'h10, 8'h80, 8'h90, 0, 0, 0, 0));
        tbl.push_back(mk(8'h20, 1, 1, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'hFF, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h9D, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'hFF, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h55, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 1));
        tbl.push_back(mk(8'h80, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'hFF, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 0));
        tbl.push_back(mk(8'h81, 1, 0, 8'h20, 8'h80, 8'h90, 1, 0, 0, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            din       = tbl[i].din;
            din_valid = tbl[i].dv;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e);
        end

        // Same two-pixel stream with din_valid toggling every cycle
        do_reset();
        stim.delete();
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
        push_bytes(8'h80, 8'h10, 8'h90, 8'h20);
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h9D);
        run_stream("toggle", 1);
        check_int("toggle_npix", npix, 2);

        // Over-long line saturates at MAX_PIX pixels
        do_reset();
        stim.delete();
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
        repeat (2 * MAX_PIX + 4) stim.push_back(8'($urandom_range(0, 254)));
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h9D);
        run_stream("longline", 0);
        check_int("longline_npix", npix, MAX_PIX);
        check_int("longline_lastx", last_x, MAX_PIX - 1);
        check_int("longline_err", nerr, 0);

        // Field start: blanking SAV then three active lines, then a bad XY
        do_reset();
        stim.delete();
        push_bytes(8'hFF, 8'h00, 8'h00, 8'hAB);
        repeat (3) begin
            push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
            push_bytes(8'h81, 8'h41, 8'h71, 8'h42);
            push_bytes(8'hFF, 8'h00, 8'h00, 8'h9D);
        end
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h81);
        run_stream("fieldseq", 2);
        check_int("fieldseq_nlines", sol_lines.size(), 3);
        for (int k = 0; k < sol_lines.size() && k < 3; k++)
            check_int($sformatf("fieldseq_line%0d", k), sol_lines[k], k);
        check_int("fieldseq_nsof", nsof, 1);
        check_int("fieldseq_nerr", nerr, 1);
        check_int("fieldseq_liney", int'(line_y), 2);

        // Broken preamble suppresses pixels until the next good SAV
        do_reset();
        stim.delete();
        stim.push_back(8'hFF); stim.push_back(8'h00); stim.push_back(8'h55);
        push_bytes(8'h80, 8'h10, 8'h90, 8'h20);
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
        push_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        run_stream("brokenpre", 0);
        check_int("brokenpre_nerr", nerr, 1);
        check_int("brokenpre_npix", npix, 2);

        // Asynchronous reset while waiting for the Cr byte
        do_reset();
        stim.delete();
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
        push_bytes(8'h80, 8'h10, 8'h90, 8'h20);
        stim.push_back(8'h80); stim.push_back(8'h10);
        run_stream("preRst", 0);
        reset_n = 1'b0;
        #1;
        check("async_reset", reset_exp());
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        stim.delete();
        stim.push_back(8'h90); stim.push_back(8'h20);
        push_bytes(8'hFF, 8'h00, 8'h00, 8'h80);
        push_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        run_stream("postRst", 0);
        check_int("postRst_npix", npix, 2);
        check_int("postRst_nsof", nsof, 1);

        // Randomized stream against the reference model
        do_reset();
        gen_random(40);
        run_stream("random", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
